spi_frame_rx: RTL

SPI receive front end for the PWM register bank. It brings the asynchronous SCLK/COPI/nCS pins into the system clock domain and deserialises 16-bit mode-0 frames. Each valid write frame becomes a single-cycle write strobe carrying address and data, which the register bank feeding the PWM engine consumes. Read frames, malformed frames and out-of-range addresses are filtered here and never produce a write.

---
 rtl/spi_frame_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 26 ++
 rtl/spi_frame_rx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/spi_frame_pkg.sv
// Shared constants and state encoding for the SPI frame receiver.
package spi_frame_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int DATA_MSB   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a history flop; edges are taken
// between the synchronised output and the history flop.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sh_q;

    // Shift the pin through sync1, sync2 and the history flop.
    always_ff @(posedge clk) begin
        if (!rst_n) sh_q <= {3{RST_VAL}};
        else        sh_q <= {sh_q[1:0], d_i};
    end

    assign sync_o = sh_q[1];
    assign rise_o = sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises the pins, deserialises 16-bit
// frames and turns valid in-range writes into a single-cycle write strobe.
module spi_frame_rx #(
    parameter logic [6:0] MAX_ADDR   = 7'h04,
    parameter int         FRAME_BITS = spi_frame_pkg::FRAME_BITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_in,
    input  logic       copi_in,
    input  logic       ncs_in,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       addr_drop,
    output logic       frame_err,
    output logic       busy
);
    import spi_frame_pkg::*;

    logic sclk_sync_unused, sclk_fall_unused, sclk_rise;
    logic ncs_sync_unused, ncs_rise, ncs_fall;
    logic copi_sync, copi_rise_unused, copi_fall_unused;

    // nCS resets low, so a frame can only start after nCS is seen high.
    sync_edge_det #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk_in),
        .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
    );
    sync_edge_det #(.RST_VAL(1'b0)) u_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs_in),
        .sync_o(ncs_sync_unused), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );
    // Same depth as SCLK so the data bit lines up with the sampling edge.
    sync_edge_det #(.RST_VAL(1'b0)) u_copi (
        .clk(clk), .rst_n(rst_n), .d_i(copi_in),
        .sync_o(copi_sync), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
    );

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [4:0]              cnt_q, cnt_d;
    logic                    wr_valid_q, wr_valid_d;
    logic                    addr_drop_q, addr_drop_d;
    logic                    frame_err_q, frame_err_d;
    logic [6:0]              wr_addr_q, wr_addr_d;
    logic [7:0]              wr_data_q, wr_data_d;
    logic [6:0]              frame_addr;

    assign frame_addr = shreg_q[ADDR_MSB:ADDR_LSB];

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            wr_valid_q  <= 1'b0;
            addr_drop_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            wr_valid_q  <= wr_valid_d;
            addr_drop_q <= addr_drop_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Next state: nCS rising takes priority over a coincident SCLK edge.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        wr_valid_d  = 1'b0;
        addr_drop_d = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        case (state_q)
            IDLE: begin
                shreg_d = '0;
                cnt_d   = '0;
                if (ncs_fall) state_d = SHIFT;
            end
            SHIFT: begin
                if (ncs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], copi_sync};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q + 5'd1 == 5'(FRAME_BITS)) state_d = DONE;
                end
            end
            DONE: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                    if (shreg_q[RW_BIT]) begin
                        if (frame_addr <= MAX_ADDR) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = frame_addr;
                            wr_data_d  = shreg_q[DATA_MSB:0];
                        end else begin
                            addr_drop_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_valid  = wr_valid_q;
    assign addr_drop = addr_drop_q;
    assign frame_err = frame_err_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != IDLE);

endmodule
